// File: rtl/tank_sensor_scanner.sv
// Two-channel tank sensor poller: req/ack handshake, threshold hysteresis and
// per-flag debounce, with timeout forcing a channel into its alarm state.
module tank_sensor_scanner #(
  parameter int TEMP_W    = 8,
  parameter int HI_THRESH = 30,
  parameter int LO_THRESH = 25,
  parameter int HYST      = 1,
  parameter int DEBOUNCE  = 4,
  parameter int TIMEOUT   = 16,
  parameter int GAP       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              req,
  output logic              req_ch,
  input  logic              ack,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              level_in,
  output logic              above_30_0,
  output logic              above_25_0,
  output logic              low_level_0,
  output logic              above_30_1,
  output logic              above_25_1,
  output logic              low_level_1,
  output logic [1:0]        fault
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [TEMP_W-1:0] HI_ON  = TEMP_W'(HI_THRESH);
  localparam logic [TEMP_W-1:0] HI_OFF = TEMP_W'(HI_THRESH - HYST);
  localparam logic [TEMP_W-1:0] LO_ON  = TEMP_W'(LO_THRESH);
  localparam logic [TEMP_W-1:0] LO_OFF = TEMP_W'(LO_THRESH - HYST);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  logic [1:0]        state;
  logic              ch;
  logic [GW-1:0]     gap_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic [TEMP_W-1:0] temp_p0;
  logic              level_p0;
  logic [1:0]        a30;
  logic [1:0]        a25;
  logic [1:0]        low;
  logic [CW-1:0]     c30  [2];
  logic [CW-1:0]     c25  [2];
  logic [CW-1:0]     clow [2];
  logic [CW:0]       d30;
  logic [CW:0]       d25;
  logic [CW:0]       dlow;

  // Inside the band between off and on levels the flag keeps its current value.
  function automatic logic hyst_target(input logic [TEMP_W-1:0] t,
                                       input logic [TEMP_W-1:0] on_lvl,
                                       input logic [TEMP_W-1:0] off_lvl,
                                       input logic              cur);
    if (t >= on_lvl)       return 1'b1;
    else if (t < off_lvl)  return 1'b0;
    else                   return cur;
  endfunction

  // Returns {new_flag, new_count}.
  function automatic logic [CW:0] debounce(input logic          flag,
                                           input logic [CW-1:0] cnt,
                                           input logic          tgt);
    if (tgt == flag)                 return {flag, CW'(0)};
    else if (cnt == CW'(DEBOUNCE-1)) return {tgt, CW'(0)};
    else                             return {flag, cnt + CW'(1)};
  endfunction

  always_comb begin
    d30  = debounce(a30[ch], c30[ch], hyst_target(temp_p0, HI_ON, HI_OFF, a30[ch]));
    d25  = debounce(a25[ch], c25[ch], hyst_target(temp_p0, LO_ON, LO_OFF, a25[ch]));
    dlow = debounce(low[ch], clow[ch], ~level_p0);
  end

  // Sample capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == REQ && ack) begin
      temp_p0  <= temp_in;
      level_p0 <= level_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= 1'b0;
      gap_cnt <= '0;
      tmo_cnt <= '0;
      tmo_hit <= 1'b0;
      fault   <= 2'b00;
      a30     <= 2'b00;
      a25     <= 2'b11;
      low     <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        c30[i]  <= '0;
        c25[i]  <= '0;
        clow[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!enable) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GW'(GAP-1)) begin
            gap_cnt <= '0;
            tmo_cnt <= '0;
            state   <= REQ;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        REQ: begin
          if (ack) begin
            tmo_hit <= 1'b0;
            state   <= UPDATE;
          end else if (tmo_cnt == TW'(TIMEOUT-1)) begin
            tmo_hit <= 1'b1;
            state   <= UPDATE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        UPDATE: begin
          if (tmo_hit) begin
            fault[ch] <= 1'b1;
            low[ch]   <= 1'b1;
            a25[ch]   <= 1'b0;
            c30[ch]   <= '0;
            c25[ch]   <= '0;
            clow[ch]  <= '0;
          end else begin
            fault[ch] <= 1'b0;
            a30[ch]   <= d30[CW];
            c30[ch]   <= d30[CW-1:0];
            a25[ch]   <= d25[CW];
            c25[ch]   <= d25[CW-1:0];
            low[ch]   <= dlow[CW];
            clow[ch]  <= dlow[CW-1:0];
          end
          tmo_cnt <= '0;
          ch      <= ~ch;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req         = (state == REQ);
  assign req_ch      = ch;
  assign above_30_0  = a30[0];
  assign above_25_0  = a25[0];
  assign low_level_0 = low[0];
  assign above_30_1  = a30[1];
  assign above_25_1  = a25[1];
  assign low_level_1 = low[1];

endmodule

// File: tb/tb_tank_sensor_scanner.sv
// Directed bench for tank_sensor_scanner: reset, debounce, hysteresis, level,
// timeout and mid-operation enable/reset scenarios with hand-derived expectations.
module tb_tank_sensor_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       req;
  logic       req_ch;
  logic       ack;
  logic [7:0] temp_in;
  logic       level_in;
  logic       above_30_0, above_25_0, low_level_0;
  logic       above_30_1, above_25_1, low_level_1;
  logic [1:0] fault;

  int passed = 0;
  int total  = 0;

  bit   got;
  logic chs;
  int   nr;

  tank_sensor_scanner dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .req_ch(req_ch),
    .ack(ack), .temp_in(temp_in), .level_in(level_in),
    .above_30_0(above_30_0), .above_25_0(above_25_0), .low_level_0(low_level_0),
    .above_30_1(above_30_1), .above_25_1(above_25_1), .low_level_1(low_level_1),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for a request, then acks it or lets it time out; returns one
  // cycle after the UPDATE edge so flag changes are visible.
  task automatic poll(input logic [7:0] t, input logic lv, input bit do_ack,
                      output bit g, output logic c, output int n);
    g = 0; c = 1'b0; n = 0;
    for (int i = 0; i < 60 && !req; i++) begin @(posedge clk); #1; end
    if (!req) begin
      total++;
      $display("FAIL poll_wait no req within 60 cycles");
      return;
    end
    g = 1; c = req_ch;
    if (do_ack) begin
      ack = 1'b1; temp_in = t; level_in = lv;
      @(posedge clk); #1;
      ack = 1'b0; n = 1;
    end else begin
      while (req && n < 100) begin @(posedge clk); #1; n++; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; enable = 1'b1; ack = 1'b0; temp_in = 8'd0; level_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req !== 1'b0) $display("FAIL rst_req got=%0b want=0", req); else passed++;
    total++; if (above_25_0 !== 1'b1 || above_25_1 !== 1'b1) $display("FAIL rst_a25 got=%0b%0b want=11", above_25_1, above_25_0); else passed++;
    total++; if ({above_30_1, above_30_0, low_level_1, low_level_0} !== 4'b0000) $display("FAIL rst_flags got=%b want=0000", {above_30_1, above_30_0, low_level_1, low_level_0}); else passed++;
    total++; if (fault !== 2'b00) $display("FAIL rst_fault got=%b want=00", fault); else passed++;
    rst_n = 1'b1;
    n = 0;
    while (!req && n < 100) begin @(posedge clk); #1; n++; end
    total++; if (n !== 8) $display("FAIL rst_first_req_cycles got=%0d want=8", n); else passed++;
    total++; if (req_ch !== 1'b0) $display("FAIL rst_first_ch got=%0b want=0", req_ch); else passed++;
  endtask

  task automatic test_debounce_set();
    for (int k = 1; k <= 4; k++) begin
      poll(8'd31, 1'b1, 1, got, chs, nr);
      if (k == 3) begin
        total++; if (above_30_0 !== 1'b0) $display("FAIL deb_a30_0_after3 got=%0b want=0", above_30_0); else passed++;
      end
      if (k == 4) begin
        total++; if (above_30_0 !== 1'b1) $display("FAIL deb_a30_0_after4 got=%0b want=1", above_30_0); else passed++;
      end
      poll(8'd27, 1'b1, 1, got, chs, nr);
      if (k == 1) begin
        total++; if (chs !== 1'b1) $display("FAIL deb_alternate_ch got=%0b want=1", chs); else passed++;
      end
    end
    total++; if ({above_30_1, above_25_1, low_level_1} !== 3'b010) $display("FAIL deb_ch1_flags got=%b want=010", {above_30_1, above_25_1, low_level_1}); else passed++;
  endtask

  task automatic test_hysteresis();
    for (int k = 1; k <= 4; k++) begin
      poll(8'd29, 1'b1, 1, got, chs, nr);
      poll(8'd27, 1'b1, 1, got, chs, nr);
    end
    total++; if (above_30_0 !== 1'b1) $display("FAIL hyst_band_hold got=%0b want=1", above_30_0); else passed++;
    for (int k = 1; k <= 4; k++) begin
      poll(8'd28, 1'b1, 1, got, chs, nr);
      if (k == 3) begin
        total++; if (above_30_0 !== 1'b1) $display("FAIL hyst_clear_after3 got=%0b want=1", above_30_0); else passed++;
      end
      if (k == 4) begin
        total++; if (above_30_0 !== 1'b0) $display("FAIL hyst_clear_after4 got=%0b want=0", above_30_0); else passed++;
      end
      poll(8'd27, 1'b1, 1, got, chs, nr);
    end
    begin
      logic [7:0] seq [5] = '{8'd31, 8'd31, 8'd31, 8'd27, 8'd31};
      for (int k = 0; k < 5; k++) begin
        poll(seq[k], 1'b1, 1, got, chs, nr);
        poll(8'd27, 1'b1, 1, got, chs, nr);
      end
    end
    total++; if (above_30_0 !== 1'b0) $display("FAIL hyst_break_seq got=%0b want=0", above_30_0); else passed++;
    total++; if (above_25_0 !== 1'b1) $display("FAIL hyst_a25_0 got=%0b want=1", above_25_0); else passed++;
  endtask

  task automatic test_level();
    for (int k = 1; k <= 4; k++) begin
      poll(8'd27, 1'b1, 1, got, chs, nr);
      poll(8'd27, 1'b0, 1, got, chs, nr);
      if (k == 3) begin
        total++; if (low_level_1 !== 1'b0) $display("FAIL lvl_after3 got=%0b want=0", low_level_1); else passed++;
      end
    end
    total++; if (low_level_1 !== 1'b1) $display("FAIL lvl_after4 got=%0b want=1", low_level_1); else passed++;
    poll(8'd27, 1'b1, 1, got, chs, nr);
    poll(8'd27, 1'b1, 1, got, chs, nr);
    total++; if (low_level_1 !== 1'b1) $display("FAIL lvl_single_ok got=%0b want=1", low_level_1); else passed++;
  endtask

  task automatic test_timeout();
    poll(8'd27, 1'b1, 1, got, chs, nr);
    poll(8'd27, 1'b1, 0, got, chs, nr);
    total++; if (chs !== 1'b1) $display("FAIL tmo_ch got=%0b want=1", chs); else passed++;
    total++; if (nr !== 16) $display("FAIL tmo_req_cycles got=%0d want=16", nr); else passed++;
    total++; if (fault !== 2'b10) $display("FAIL tmo_fault got=%b want=10", fault); else passed++;
    total++; if ({above_30_1, above_25_1, low_level_1} !== 3'b001) $display("FAIL tmo_forced got=%b want=001", {above_30_1, above_25_1, low_level_1}); else passed++;
    total++; if ({above_30_0, above_25_0, low_level_0} !== 3'b010) $display("FAIL tmo_ch0_untouched got=%b want=010", {above_30_0, above_25_0, low_level_0}); else passed++;
    for (int k = 1; k <= 4; k++) begin
      poll(8'd27, 1'b1, 1, got, chs, nr);
      if (k == 1) begin
        total++; if (chs !== 1'b0) $display("FAIL tmo_next_ch got=%0b want=0", chs); else passed++;
      end
      poll(8'd27, 1'b1, 1, got, chs, nr);
      if (k == 1) begin
        total++; if (fault !== 2'b00) $display("FAIL tmo_fault_clear got=%b want=00", fault); else passed++;
      end
      if (k == 3) begin
        total++; if ({above_25_1, low_level_1} !== 2'b01) $display("FAIL tmo_recover_after3 got=%b want=01", {above_25_1, low_level_1}); else passed++;
      end
    end
    total++; if ({above_25_1, low_level_1} !== 2'b10) $display("FAIL tmo_recover_after4 got=%b want=10", {above_25_1, low_level_1}); else passed++;
  endtask

  task automatic test_enable_mid();
    int n;
    n = 0;
    while (!req && n < 60) begin @(posedge clk); #1; n++; end
    enable = 1'b0; ack = 1'b1; temp_in = 8'd27; level_in = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    total++; if (req !== 1'b0) $display("FAIL en_req_after_ack got=%0b want=0", req); else passed++;
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (req) n++; end
    total++; if (n !== 0) $display("FAIL en_no_req_while_disabled got=%0d want=0", n); else passed++;
    enable = 1'b1;
    n = 0;
    while (!req && n < 60) begin @(posedge clk); #1; n++; end
    total++; if (req !== 1'b1 || req_ch !== 1'b1) $display("FAIL en_resume got=req%0b ch%0b want=req1 ch1", req, req_ch); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (req && n < 60) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    total++; if (fault !== 2'b10 || low_level_1 !== 1'b1) $display("FAIL rm_pre_timeout got=fault%b low%0b want=fault10 low1", fault, low_level_1); else passed++;
    n = 0;
    while (!req && n < 60) begin @(posedge clk); #1; n++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (req !== 1'b0 || req_ch !== 1'b0) $display("FAIL rm_req got=req%0b ch%0b want=req0 ch0", req, req_ch); else passed++;
    total++; if (fault !== 2'b00) $display("FAIL rm_fault got=%b want=00", fault); else passed++;
    total++; if ({above_30_1, above_25_1, low_level_1, above_30_0, above_25_0, low_level_0} !== 6'b010010) $display("FAIL rm_flags got=%b want=010010", {above_30_1, above_25_1, low_level_1, above_30_0, above_25_0, low_level_0}); else passed++;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_debounce_set();
    test_hysteresis();
    test_level();
    test_timeout();
    test_enable_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tank_sensor_scanner.md
# tank_sensor_scanner

Sensor-side front end that produces the per-tank alarm flags (`above_30_x`, `above_25_x`, `low_level_x`) consumed by the buzzer logic. It alternately polls two tanks' temperature/level sensor over a req/ack handshake. It applies threshold hysteresis and consecutive-sample debounce to the readings, and forces an alarm-raising state on a channel whose sensor stops answering.

## Interface
- `TEMP_W`, 8 — width of temperature sample, unsigned °C
- `HI_THRESH`, 30 — over-temperature threshold
- `LO_THRESH`, 25 — under-temperature threshold
- `HYST`, 1 — hysteresis band below each threshold; constraint `HYST <= LO_THRESH` and `HYST < HI_THRESH-LO_THRESH`
- `DEBOUNCE`, 4 — consecutive same-channel samples needed to change a flag (≥1)
- `TIMEOUT`, 16 — cycles in REQ without ack before declaring fault (≥1)
- `GAP`, 8 — idle cycles between transactions (≥1)

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1 — sole clock, rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `enable` in 1 — scanning enabled
- `req` out 1 — sample request to sensor bus
- `req_ch` out 1 — channel being requested
- `ack` in 1 — sensor response strobe, valid only while `req`=1
- `temp_in` in TEMP_W — temperature, sampled on ack
- `level_in` in 1 — level switch, 1 = level OK, sampled on ack
- `above_30_0`, `above_25_0`, `low_level_0` out 1 each — channel 0 flags
- `above_30_1`, `above_25_1`, `low_level_1` out 1 each — channel 1 flags
- `fault` out 2 — per-channel sensor timeout flag

## Operation
- States:
  - IDLE: counts GAP cycles while `enable`=1; counter held at 0 while `enable`=0. IDLE → REQ when the count reaches GAP.
  - REQ: `req`=1 (Moore), `req_ch`=current channel.
    - `ack`=1 at an edge → capture `temp_in`/`level_in`, go to UPDATE.
    - Else the timeout counter increments. On the TIMEOUT-th cycle without ack, go to UPDATE with the timeout marker set.
  - UPDATE: one cycle. Updates the current channel's flags, toggles the channel, and returns to IDLE.
- `ack` while not in REQ is ignored.
- Hysteresis targets (unsigned compare, TEMP_W bits):
  - above_30 target = 1 if `temp>=HI_THRESH`; 0 if `temp<HI_THRESH-HYST`; else current value.
  - above_25 target = 1 if `temp>=LO_THRESH`; 0 if `temp<LO_THRESH-HYST`; else current value.
  - low_level target = `~level_in`.
- Debounce:
  - Each flag has its own counter (`clog2(DEBOUNCE+1)` bits).
  - A sample whose target differs from the flag increments the counter. When the counter reaches DEBOUNCE, the flag takes the target and the counter clears.
  - A sample whose target equals the flag clears the counter.
  - With DEBOUNCE=1, the flag follows the target every sample.
- Timeout UPDATE:
  - Sets `fault[ch]`=1.
  - Forces `low_level_ch`=1 and `above_25_ch`=0; `above_30_ch` is held.
  - Clears that channel's debounce counters.
- A successful UPDATE clears `fault[ch]`. Flags then resume from their forced values, subject to debounce.
- `enable` deasserted mid-transaction: the current REQ/UPDATE completes normally, then the block stays in IDLE.

## Timing
- Reset values: `req`=0, `req_ch`=0, all `above_30_x`=0, all `above_25_x`=1, all `low_level_x`=0, `fault`=2'b00. FSM goes to IDLE with channel 0, and all counters are 0.
- `rst_n` low at any edge (including mid-REQ) restores reset values at that edge, so `req` is low in the following cycle.
- `enable` rising at edge e0 → `req` high after edge e0+GAP.
- Ack sampled at edge k → `req` low and state = UPDATE after edge k. Flags and `fault` change at edge k+1, visible in the cycle after k+1.
- Timeout: the first REQ cycle counts as 1. With no ack through TIMEOUT REQ cycles, the FSM leaves REQ at the edge ending the TIMEOUT-th cycle.
- Channels strictly alternate 0,1,0,… regardless of fault. Only the polled channel's flags change in UPDATE.
- Flag outputs are registered with no glitches; all six flags and `fault` change only at the UPDATE edge.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `enable`=1 → `req`=0, `above_25_0/1`=1, all other flags 0, `fault`=0. First `req` appears exactly GAP cycles after release, with `req_ch`=0.
- Debounce set: ch0 `temp_in`=31 acked on every ch0 poll, ch1 `temp_in`=27 → `above_30_0` rises at the 4th ch0 UPDATE edge, not the 3rd; ch1 flags remain 0/1/0.
- Hysteresis/debounce break:
  - ch0 samples 31×4 set the flag; then 29×4 leave it at 1; then 28×4 clear it.
  - Separately, the sequence 31,31,31,27,31 never sets the flag.
- Level: ch1 `level_in`=0 for 4 polls → `low_level_1`=1; a single `level_in`=1 leaves it at 1.
- Timeout: no ack on a ch1 request → after 16 REQ cycles `req` drops, `fault`=2'b10, `low_level_1`=1, `above_25_1`=0. The next request is ch0. A subsequent ch1 ack clears `fault[1]`, and the flags need 4 samples to recover.
- Enable/reset mid-op:
  - Drop `enable` while `req`=1, then ack → UPDATE occurs and no further `req` is issued.
  - Assert `rst_n`=0 during REQ → `req`=0 next cycle and all flags return to reset values.
